uart_tx_sched: RTL



---
 rtl/uart_sched_pkg.sv | 31 +++
 rtl/tx_byte_buf.sv | 82 ++++++++
 rtl/uart_tx_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_sched_pkg                                          |
// | Brief  : Shared types and constants for the UART TX scheduler.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package uart_sched_pkg;

  // Upper bound on the telemetry packet payload length
  localparam int MAX_TLM_BYTES = 8;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Requester identity, remembered for round-robin arbitration
  typedef enum logic {
    SRC_ACK = 1'b0,
    SRC_TLM = 1'b1
  } src_t;

  // Total telemetry packet length including the optional header
  function automatic int tlm_pkt_bytes(input int tlm_bytes, input bit hdr_en);
    return tlm_bytes + (hdr_en ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_byte_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tx_byte_buf                                             |
// | Brief  : Latched packet store for the UART TX scheduler. Holds   |
// |          the ack byte or the (optionally headed) telemetry       |
// |          payload, its length, and serves bytes by index.         |
// |          Build option: TX_HDR_EN prepends HDR_BYTE to telemetry. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tx_byte_buf
  import uart_sched_pkg::*;
#(
  parameter int          TLM_BYTES = 3,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5,
  parameter int          IDX_W     = $clog2(TLM_BYTES + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   load_tlm,
  input  logic [7:0]             ack_byte,
  input  logic [8*TLM_BYTES-1:0] tlm_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [7:0]             first_byte,
  output logic [7:0]             rd_byte,
  output logic [IDX_W-1:0]       pkt_len
);

`ifdef TX_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
  // Header byte has no consumer without the header option
  logic [7:0] unused_hdr;
  assign unused_hdr = HDR_BYTE;
`endif

  localparam int PKT_BYTES = tlm_pkt_bytes(TLM_BYTES, HDR_EN);

  // Byte 0 of the packet lives in the most significant byte lane
  logic [8*PKT_BYTES-1:0] pkt_q;
  logic [7:0]             tlm_first;

`ifdef TX_HDR_EN
  assign tlm_first = HDR_BYTE;
`else
  assign tlm_first = tlm_data[8*TLM_BYTES-1 -: 8];
`endif

  // First byte of the packet being loaded, so the grant edge can also launch it
  assign first_byte = load_tlm ? tlm_first : ack_byte;

  // Capture the granted payload and its length on the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      pkt_len <= '0;
    end else if (load) begin
      if (load_tlm) begin
`ifdef TX_HDR_EN
        pkt_q <= {HDR_BYTE, tlm_data};
`else
        pkt_q <= tlm_data;
`endif
        pkt_len <= IDX_W'(PKT_BYTES);
      end else begin
        pkt_q[8*PKT_BYTES-1 -: 8] <= ack_byte;
        pkt_len                   <= IDX_W'(1);
      end
    end
  end

  // Byte selection by packet index; out-of-range indices read as zero
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (rd_idx == IDX_W'(i)) rd_byte = pkt_q[8*(PKT_BYTES-i)-1 -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_tx_sched                                           |
// | Brief  : Transmit scheduler for the shared UART. Round-robin     |
// |          arbitration between ack and telemetry requesters, then  |
// |          byte-by-byte sequencing on trmt/tx_data paced by        |
// |          tx_done. Build option: TX_HDR_EN (telemetry header).    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int         TLM_BYTES = 3,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ack_req,
  input  logic [7:0]             ack_byte,
  output logic                   ack_gnt,
  input  logic                   tlm_req,
  input  logic [8*TLM_BYTES-1:0] tlm_data,
  output logic                   tlm_gnt,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy
);

  localparam int IDX_W = $clog2(TLM_BYTES + 2);

  state_t           state;
  src_t             last_src;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] pkt_len;
  logic [7:0]       first_byte;
  logic [7:0]       rd_byte;
  logic             grant_ack;
  logic             grant_tlm;
  logic             load;
  logic             more_bytes;

  // Round-robin arbitration: ack wins a tie unless it won the previous grant
  always_comb begin
    grant_ack  = ack_req && (!tlm_req || (last_src == SRC_TLM));
    grant_tlm  = tlm_req && !grant_ack;
    load       = (state == IDLE) && (ack_req || tlm_req);
    idx_nxt    = idx + IDX_W'(1);
    more_bytes = idx_nxt < pkt_len;
  end

  tx_byte_buf #(
    .TLM_BYTES (TLM_BYTES),
    .HDR_BYTE  (HDR_BYTE),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_tlm   (grant_tlm),
    .ack_byte   (ack_byte),
    .tlm_data   (tlm_data),
    .rd_idx     (idx_nxt),
    .first_byte (first_byte),
    .rd_byte    (rd_byte),
    .pkt_len    (pkt_len)
  );

  // Scheduler FSM: grant in IDLE, skip the stale tx_done in GUARD, pace in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      last_src <= SRC_TLM;
      trmt     <= 1'b0;
      tx_data  <= 8'h00;
      ack_gnt  <= 1'b0;
      tlm_gnt  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trmt    <= 1'b0;
      ack_gnt <= 1'b0;
      tlm_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= GUARD;
            idx      <= '0;
            trmt     <= 1'b1;
            tx_data  <= first_byte;
            busy     <= 1'b1;
            ack_gnt  <= grant_ack;
            tlm_gnt  <= grant_tlm;
            last_src <= grant_ack ? SRC_ACK : SRC_TLM;
          end
        end
        GUARD: begin
          // The UART has not yet cleared tx_done for the byte just launched
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (more_bytes) begin
              idx     <= idx_nxt;
              trmt    <= 1'b1;
              tx_data <= rd_byte;
              state   <= GUARD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
